// File: rtl/encoder_core_mc.sv
// Multi-channel quadrature decoder: sync, glitch filter, x1/x2/x4 decode,
// wrapping position, windowed velocity, index latch and sticky AB error.
module encoder_core_mc #(
    parameter int NUM_CH        = 2,
    parameter int POS_WIDTH     = 32,
    parameter int WINDOW_CYCLES = 100000,
    parameter int FILTER_LEN    = 3
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_CH-1:0]           enable,
    input  logic [NUM_CH-1:0]           clr_pos,
    input  logic [1:0]                  mode,
    input  logic [NUM_CH-1:0]           index_en,
    input  logic [NUM_CH-1:0]           err_clr,
    input  logic [NUM_CH-1:0]           enc_a,
    input  logic [NUM_CH-1:0]           enc_b,
    input  logic [NUM_CH-1:0]           enc_z,
    output logic [NUM_CH*POS_WIDTH-1:0] position,
    output logic [NUM_CH*POS_WIDTH-1:0] velocity,
    output logic [NUM_CH*POS_WIDTH-1:0] index_pos,
    output logic [NUM_CH-1:0]           direction,
    output logic [NUM_CH-1:0]           index_hit,
    output logic [NUM_CH-1:0]           err
);

    localparam int PW = POS_WIDTH;
    localparam int CW = $clog2(FILTER_LEN + 1);
    localparam int WW = $clog2(WINDOW_CYCLES);
    localparam logic [PW-1:0] MAXV = {1'b0, {(PW-1){1'b1}}};
    localparam logic [PW-1:0] MINV = {1'b1, {(PW-1){1'b0}}};

    logic [WW-1:0] r_win;
    logic [1:0]    r_warm;
    logic          w_win_last;
    logic          w_warm;

    assign w_win_last = (r_win == WW'(WINDOW_CYCLES - 1));
    assign w_warm     = r_warm[1];

    // Filters hold off until the sync chain carries real pin samples.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_win  <= '0;
            r_warm <= '0;
        end else begin
            r_win <= w_win_last ? '0 : r_win + 1'b1;
            if (!w_warm) r_warm <= r_warm + 1'b1;
        end
    end

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        logic [2:0]    w_pin;
        logic [2:0]    r_s1, r_s2, r_cand, r_filt, r_ok;
        logic [CW-1:0] r_cnt  [3];
        logic [CW-1:0] w_ncnt [3];

        assign w_pin = {enc_z[ch], enc_a[ch], enc_b[ch]};

        always_comb begin
            for (int p = 0; p < 3; p++) begin
                w_ncnt[p] = r_cnt[p] + 1'b1;
                if (r_s2[p] != r_cand[p])
                    w_ncnt[p] = CW'(1);
                else if (r_cnt[p] == CW'(FILTER_LEN))
                    w_ncnt[p] = r_cnt[p];
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                r_s1   <= '0;
                r_s2   <= '0;
                r_cand <= '0;
                r_filt <= '0;
                r_ok   <= '0;
                for (int p = 0; p < 3; p++) r_cnt[p] <= '0;
            end else begin
                r_s1 <= w_pin;
                r_s2 <= r_s1;
                if (w_warm) begin
                    r_cand <= r_s2;
                    for (int p = 0; p < 3; p++) begin
                        r_cnt[p] <= w_ncnt[p];
                        if (w_ncnt[p] == CW'(FILTER_LEN)) begin
                            r_filt[p] <= r_s2[p];
                            r_ok[p]   <= 1'b1;
                        end
                    end
                end
            end
        end

        logic          r_primed, r_zprev, r_dir, r_err, r_hit;
        logic [1:0]    r_prev;
        logic [PW-1:0] r_pos, r_ipos, r_vacc, r_vel;
        logic [1:0]    w_cur;
        logic          w_chg, w_ill, w_fwd, w_qual, w_step, w_zrise, w_idx;
        logic [PW-1:0] w_base, w_vnext;

        assign w_cur   = r_filt[1:0];
        assign w_chg   = r_primed && (w_cur != r_prev);
        assign w_ill   = w_chg && (w_cur == ~r_prev);
        assign w_step  = w_chg && !w_ill && w_qual && enable[ch];
        assign w_zrise = r_ok[2] && r_filt[2] && !r_zprev;
        assign w_idx   = w_zrise && index_en[ch] && enable[ch]
                         && !clr_pos[ch];

        always_comb begin
            w_fwd = 1'b0;
            case ({r_prev, w_cur})
                4'b0001, 4'b0111, 4'b1110, 4'b1000: w_fwd = 1'b1;
                default:                            w_fwd = 1'b0;
            endcase
            w_qual = 1'b1;
            case (mode)
                2'b01:   w_qual = r_prev[1] ^ w_cur[1];
                2'b10:   w_qual = ({r_prev, w_cur} == 4'b0111)
                                  || ({r_prev, w_cur} == 4'b1101);
                default: w_qual = 1'b1;
            endcase
        end

        // Velocity saturates; a step on the window boundary opens the new window.
        always_comb begin
            w_base  = w_win_last ? '0 : r_vacc;
            w_vnext = w_base;
            if (w_step) begin
                if (w_fwd)
                    w_vnext = (w_base == MAXV) ? w_base : w_base + 1'b1;
                else
                    w_vnext = (w_base == MINV) ? w_base : w_base - 1'b1;
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                r_primed <= 1'b0;
                r_prev   <= '0;
                r_zprev  <= 1'b0;
                r_dir    <= 1'b0;
                r_err    <= 1'b0;
                r_hit    <= 1'b0;
                r_pos    <= '0;
                r_ipos   <= '0;
                r_vacc   <= '0;
                r_vel    <= '0;
            end else begin
                r_zprev <= r_filt[2];
                if (r_primed)
                    r_prev <= w_cur;
                else if (r_ok[1] && r_ok[0]) begin
                    r_prev   <= w_cur;
                    r_primed <= 1'b1;
                end
                r_err <= w_ill || (r_err && !err_clr[ch]);
                r_hit <= w_idx;
                if (clr_pos[ch])
                    r_pos <= '0;
                else if (w_idx) begin
                    r_ipos <= r_pos;
                    r_pos  <= '0;
                end else if (w_step) begin
                    r_pos <= w_fwd ? r_pos + 1'b1 : r_pos - 1'b1;
                    r_dir <= w_fwd;
                end
                r_vacc <= w_vnext;
                if (w_win_last) r_vel <= r_vacc;
            end
        end

        assign position[ch*PW +: PW]  = r_pos;
        assign velocity[ch*PW +: PW]  = r_vel;
        assign index_pos[ch*PW +: PW] = r_ipos;
        assign direction[ch]          = r_dir;
        assign index_hit[ch]          = r_hit;
        assign err[ch]                = r_err;
    end

endmodule

// File: tb/tb_encoder_core_mc.sv
// Directed bench for encoder_core_mc: a 32-bit instance and an 8-bit
// instance share stimulus; the 8-bit one exercises position wrap.
module tb_encoder_core_mc;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] enable, clr_pos, index_en, err_clr;
    logic [1:0] enc_a, enc_b, enc_z, mode;
    logic [63:0] pos32, vel32, ipos32;
    logic [15:0] pos8, vel8, ipos8;
    logic [1:0]  dir32, hit32, err32, dir8, hit8, err8;
    logic [1:0]  cur_ab;
    int checks   = 0;
    int failures = 0;
    int hits;

    always #5 clk = ~clk;

    encoder_core_mc #(.NUM_CH(2), .POS_WIDTH(32), .WINDOW_CYCLES(10),
                      .FILTER_LEN(3)) dut32 (
        .clk(clk), .reset(reset), .enable(enable), .clr_pos(clr_pos),
        .mode(mode), .index_en(index_en), .err_clr(err_clr),
        .enc_a(enc_a), .enc_b(enc_b), .enc_z(enc_z),
        .position(pos32), .velocity(vel32), .index_pos(ipos32),
        .direction(dir32), .index_hit(hit32), .err(err32));

    encoder_core_mc #(.NUM_CH(2), .POS_WIDTH(8), .WINDOW_CYCLES(10),
                      .FILTER_LEN(3)) dut8 (
        .clk(clk), .reset(reset), .enable(enable), .clr_pos(clr_pos),
        .mode(mode), .index_en(index_en), .err_clr(err_clr),
        .enc_a(enc_a), .enc_b(enc_b), .enc_z(enc_z),
        .position(pos8), .velocity(vel8), .index_pos(ipos8),
        .direction(dir8), .index_hit(hit8), .err(err8));

    function automatic logic [1:0] nf(input logic [1:0] ab);
        case (ab)
            2'b00: nf = 2'b01;
            2'b01: nf = 2'b11;
            2'b11: nf = 2'b10;
            default: nf = 2'b00;
        endcase
    endfunction

    function automatic logic [1:0] nr(input logic [1:0] ab);
        case (ab)
            2'b00: nr = 2'b10;
            2'b10: nr = 2'b11;
            2'b11: nr = 2'b01;
            default: nr = 2'b00;
        endcase
    endfunction

    task automatic set_ab(input logic [1:0] ab, input int hold);
        @(negedge clk);
        enc_a[0] = ab[1];
        enc_b[0] = ab[0];
        cur_ab   = ab;
        repeat (hold) @(negedge clk);
    endtask

    task automatic fwd(input int n, input int hold);
        repeat (n) set_ab(nf(cur_ab), hold);
    endtask

    task automatic rev(input int n, input int hold);
        repeat (n) set_ab(nr(cur_ab), hold);
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        clr_pos[0] = 1'b1;
        repeat (2) @(negedge clk);
        clr_pos[0] = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({pos32, vel32, ipos32, dir32, hit32, err32} !== '0) begin
            failures++;
            $display("FAIL reset32 got=%h exp=0",
                     {pos32, vel32, ipos32, dir32, hit32, err32});
        end
        checks++;
        if ({pos8, vel8, ipos8, dir8, hit8, err8} !== '0) begin
            failures++;
            $display("FAIL reset8 got=%h exp=0",
                     {pos8, vel8, ipos8, dir8, hit8, err8});
        end
        reset = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    task automatic test_forward();
        fwd(2000, 7);
        checks++;
        if (pos32[31:0] !== 32'd2000) begin
            failures++;
            $display("FAIL fwd_pos got=%0d exp=2000", pos32[31:0]);
        end
        checks++;
        if (pos8[7:0] !== 8'd208) begin
            failures++;
            $display("FAIL fwd_pos8 got=%0d exp=208", pos8[7:0]);
        end
        checks++;
        if ({dir32[0], err32[0]} !== 2'b10) begin
            failures++;
            $display("FAIL fwd_dir_err got=%b exp=10", {dir32[0], err32[0]});
        end
    endtask

    task automatic test_reverse();
        rev(1000, 7);
        checks++;
        if (pos32[31:0] !== 32'd1000 || dir32[0] !== 1'b0) begin
            failures++;
            $display("FAIL rev_pos got=%0d/%b exp=1000/0",
                     pos32[31:0], dir32[0]);
        end
    endtask

    task automatic test_modes();
        mode = 2'b01;
        fwd(40, 7);
        checks++;
        if (pos32[31:0] !== 32'd1020) begin
            failures++;
            $display("FAIL x2_fwd got=%0d exp=1020", pos32[31:0]);
        end
        rev(20, 7);
        checks++;
        if (pos32[31:0] !== 32'd1010) begin
            failures++;
            $display("FAIL x2_rev got=%0d exp=1010", pos32[31:0]);
        end
        mode = 2'b10;
        fwd(40, 7);
        checks++;
        if (pos32[31:0] !== 32'd1020 || dir32[0] !== 1'b1) begin
            failures++;
            $display("FAIL x1_fwd got=%0d/%b exp=1020/1",
                     pos32[31:0], dir32[0]);
        end
        rev(12, 7);
        checks++;
        if (pos32[31:0] !== 32'd1017 || dir32[0] !== 1'b0) begin
            failures++;
            $display("FAIL x1_rev got=%0d/%b exp=1017/0",
                     pos32[31:0], dir32[0]);
        end
    endtask

    task automatic test_error();
        set_ab(2'b11, 8);
        checks++;
        if (err32[0] !== 1'b1 || pos32[31:0] !== 32'd1017) begin
            failures++;
            $display("FAIL err_set got=%b/%0d exp=1/1017",
                     err32[0], pos32[31:0]);
        end
        @(negedge clk);
        err_clr[0] = 1'b1;
        @(negedge clk);
        err_clr[0] = 1'b0;
        @(negedge clk);
        checks++;
        if (err32[0] !== 1'b0) begin
            failures++;
            $display("FAIL err_clr got=%b exp=0", err32[0]);
        end
        enc_a[0] = 1'b0;
        @(negedge clk);
        enc_a[0] = 1'b1;
        repeat (10) @(negedge clk);
        checks++;
        if (pos32[31:0] !== 32'd1017 || err32[0] !== 1'b0) begin
            failures++;
            $display("FAIL glitch got=%0d/%b exp=1017/0",
                     pos32[31:0], err32[0]);
        end
        fwd(2, 7);
        mode = 2'b00;
    endtask

    task automatic test_wrap();
        pulse_clr();
        fwd(127, 7);
        checks++;
        if (pos8[7:0] !== 8'h7F || pos32[31:0] !== 32'd127) begin
            failures++;
            $display("FAIL wrap_pre got=%h/%0d exp=7f/127",
                     pos8[7:0], pos32[31:0]);
        end
        fwd(1, 7);
        checks++;
        if (pos8[7:0] !== 8'h80 || pos32[31:0] !== 32'd128) begin
            failures++;
            $display("FAIL wrap_max got=%h/%0d exp=80/128",
                     pos8[7:0], pos32[31:0]);
        end
        @(negedge clk);
        clr_pos[0] = 1'b1;
        set_ab(nr(cur_ab), 9);
        clr_pos[0] = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (pos8[7:0] !== 8'h00 || pos32[31:0] !== 32'd0
            || dir32[0] !== 1'b1) begin
            failures++;
            $display("FAIL clr_step got=%h/%0d/%b exp=00/0/1",
                     pos8[7:0], pos32[31:0], dir32[0]);
        end
        rev(1, 7);
        checks++;
        if (pos8[7:0] !== 8'hFF || pos32[31:0] !== 32'hFFFF_FFFF
            || dir8[0] !== 1'b0) begin
            failures++;
            $display("FAIL wrap_min got=%h/%h/%b exp=ff/ffffffff/0",
                     pos8[7:0], pos32[31:0], dir8[0]);
        end
    endtask

    task automatic test_velocity();
        for (int k = 0; k < 12; k++) begin
            set_ab(nf(cur_ab), 9);
            if (k == 5 || k == 8 || k == 11) begin
                checks++;
                if (vel32[31:0] !== 32'd1 || vel8[7:0] !== 8'd1) begin
                    failures++;
                    $display("FAIL vel_ch0 k=%0d got=%0d/%0d exp=1",
                             k, vel32[31:0], vel8[7:0]);
                end
                checks++;
                if (vel32[63:32] !== 32'd0) begin
                    failures++;
                    $display("FAIL vel_ch1 got=%0d exp=0", vel32[63:32]);
                end
            end
        end
    endtask

    task automatic test_index();
        pulse_clr();
        fwd(37, 7);
        checks++;
        if (pos32[31:0] !== 32'd37) begin
            failures++;
            $display("FAIL idx_pre got=%0d exp=37", pos32[31:0]);
        end
        @(negedge clk);
        index_en[0] = 1'b1;
        enc_z[0]    = 1'b1;
        hits = 0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            hits += int'(hit32[0]);
        end
        checks++;
        if (hits !== 1) begin
            failures++;
            $display("FAIL idx_hit got=%0d exp=1", hits);
        end
        checks++;
        if (ipos32[31:0] !== 32'd37 || pos32[31:0] !== 32'd0) begin
            failures++;
            $display("FAIL idx_cap got=%0d/%0d exp=37/0",
                     ipos32[31:0], pos32[31:0]);
        end
        enc_z[0] = 1'b0;
        repeat (8) @(negedge clk);
        index_en[0] = 1'b0;
        fwd(1, 7);
        enc_z[0] = 1'b1;
        hits = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            hits += int'(hit32[0]);
        end
        checks++;
        if (hits !== 0 || pos32[31:0] !== 32'd1
            || ipos32[31:0] !== 32'd37) begin
            failures++;
            $display("FAIL idx_off got=%0d/%0d/%0d exp=0/1/37",
                     hits, pos32[31:0], ipos32[31:0]);
        end
    endtask

    task automatic test_reprime();
        @(negedge clk);
        enc_a[0] = 1'b1;
        enc_b[0] = 1'b1;
        cur_ab   = 2'b11;
        reset    = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        checks++;
        if (err32[0] !== 1'b0 || pos32[31:0] !== 32'd0
            || ipos32[31:0] !== 32'd0) begin
            failures++;
            $display("FAIL reprime got=%b/%0d/%0d exp=0/0/0",
                     err32[0], pos32[31:0], ipos32[31:0]);
        end
        fwd(1, 7);
        checks++;
        if (pos32[31:0] !== 32'd1 || err32[0] !== 1'b0) begin
            failures++;
            $display("FAIL reprime_step got=%0d/%b exp=1/0",
                     pos32[31:0], err32[0]);
        end
    endtask

    initial begin
        reset    = 1'b1;
        enable   = 2'b11;
        clr_pos  = 2'b00;
        index_en = 2'b00;
        err_clr  = 2'b00;
        mode     = 2'b00;
        enc_a    = 2'b00;
        enc_b    = 2'b00;
        enc_z    = 2'b00;
        cur_ab   = 2'b00;
        test_reset();
        test_forward();
        test_reverse();
        test_modes();
        test_error();
        test_wrap();
        test_velocity();
        test_index();
        test_reprime();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
